// File: rtl/lsb_gen2_pkg.sv
// Shared definitions for the load/store buffer: widths, opcode and access-size codes.
package lsb_gen2_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 32;

   // Memory opcode encodings as carried on de_op_in
   localparam logic [2:0] LSB_B  = 3'b000;
   localparam logic [2:0] LSB_H  = 3'b001;
   localparam logic [2:0] LSB_W  = 3'b010;
   localparam logic [2:0] LSB_BU = 3'b100;
   localparam logic [2:0] LSB_HU = 3'b101;

   // mem_d_type access sizes
   localparam logic [1:0] DT_BYTE = 2'b01;
   localparam logic [1:0] DT_HALF = 2'b10;
   localparam logic [1:0] DT_WORD = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StWaitLd,
      StWaitSt
   } lsb_state_e;

   function automatic logic [1:0] op_to_dtype(input logic [2:0] op);
      case (op)
         LSB_B, LSB_BU: return DT_BYTE;
         LSB_H, LSB_HU: return DT_HALF;
         default:       return DT_WORD;
      endcase
   endfunction

endpackage

// File: rtl/lsb_gen2_if.sv
// Memory request/response bus between the load/store buffer and the memory controller.
interface lsb_gen2_if;
   import lsb_gen2_pkg::*;

   logic              mem_req;
   logic              mem_rw;
   logic [1:0]        mem_d_type;
   logic [ADDR_W-1:0] mem_aout;
   logic [DATA_W-1:0] mem_dout;
   logic              mem_done;
   logic [DATA_W-1:0] mem_din;

   modport master (
      output mem_req, mem_rw, mem_d_type, mem_aout, mem_dout,
      input  mem_done, mem_din
   );

   modport slave (
      input  mem_req, mem_rw, mem_d_type, mem_aout, mem_dout,
      output mem_done, mem_din
   );

endinterface

// File: rtl/lsb_load_ext.sv
// Sign/zero extension of raw load data according to the load opcode.
module lsb_load_ext
   import lsb_gen2_pkg::*;
(
   input  logic [2:0]        i_op,
   input  logic [DATA_W-1:0] i_raw,
   output logic [DATA_W-1:0] o_val
);

   // Select extension by opcode; words pass through untouched
   always_comb begin
      o_val = i_raw;
      case (i_op)
         LSB_B:   o_val = {{24{i_raw[7]}}, i_raw[7:0]};
         LSB_H:   o_val = {{16{i_raw[15]}}, i_raw[15:0]};
         LSB_BU:  o_val = {24'b0, i_raw[7:0]};
         LSB_HU:  o_val = {16'b0, i_raw[15:0]};
         default: o_val = i_raw;
      endcase
   end

endmodule

// File: rtl/lsb_gen2.sv
// In-order load/store buffer: operand wakeup, commit tracking, single outstanding memory op.
module lsb_gen2
   import lsb_gen2_pkg::*;
#(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned ROB_IDX_W   = 4,
   parameter int unsigned FULL_MARGIN = 3,
   parameter logic [1:0]  IO_SEL      = 2'b11
) (
   input  logic                   clk,
   input  logic                   rst_in,
   input  logic                   rdy_in,
   input  logic                   roll_back,
   input  logic                   de_in_en,
   input  logic                   de_rw_in,
   input  logic [2:0]             de_op_in,
   input  logic [DATA_W-1:0]      de_Vj_in,
   input  logic [DATA_W-1:0]      de_Vk_in,
   input  logic [DATA_W-1:0]      de_offset_in,
   input  logic                   de_Qj_in_en,
   input  logic                   de_Qk_in_en,
   input  logic [ROB_IDX_W-1:0]   de_Qj_in,
   input  logic [ROB_IDX_W-1:0]   de_Qk_in,
   input  logic [ROB_IDX_W-1:0]   de_rob_idx_in,
   input  logic                   rs_in_en,
   input  logic [ROB_IDX_W-1:0]   rs_rob_idx_in,
   input  logic [DATA_W-1:0]      rs_val_in,
   input  logic                   rob_committed_en,
   input  logic [ROB_IDX_W-1:0]   rob_committed_idx,
   lsb_gen2_if.master             mem,
   output logic                   lsb_full,
   output logic [$clog2(DEPTH):0] lsb_count,
   output logic                   cdb_out_en,
   output logic [ROB_IDX_W-1:0]   cdb_rob_idx_out,
   output logic [DATA_W-1:0]      cdb_val_out
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [PTR_W:0]   cnt_t;

   typedef struct packed {
      logic                 valid;
      logic                 rw;
      logic                 committed;
      logic                 qj_en;
      logic                 qk_en;
      logic [2:0]           op;
      logic [DATA_W-1:0]    vj;
      logic [DATA_W-1:0]    vk;
      logic [DATA_W-1:0]    offset;
      logic [ROB_IDX_W-1:0] qj;
      logic [ROB_IDX_W-1:0] qk;
      logic [ROB_IDX_W-1:0] tag;
   } entry_t;

   entry_t            r_ent [DEPTH];
   entry_t            w_ent_n [DEPTH];
   entry_t            w_head;
   ptr_t              r_front, r_rear, w_front_n, w_rear_n;
   cnt_t              r_count, r_ccount, w_count_n, w_ccount_n;
   lsb_state_e        r_state, w_state_n;
   logic              r_drop, r_if_cmt;
   logic [2:0]        r_if_op;
   logic [ROB_IDX_W-1:0] r_if_tag;
   logic              r_mem_req, r_mem_rw;
   logic [1:0]        r_mem_type;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_data;
   logic              r_cdb_en;
   logic [ROB_IDX_W-1:0] r_cdb_tag;
   logic [DATA_W-1:0] r_cdb_val, w_ext_val;
   logic [ADDR_W-1:0] w_addr;
   logic [DEPTH-1:0]  w_cmt_hit;
   logic              w_rb, w_disp, w_issue, w_mem_fin, w_ld_fin, w_drop_now, w_cmt_inc;

   // Returns {hit, value}: wakeup of a pending tag from the RS or CDB broadcast
   function automatic logic [DATA_W:0] fwd(input logic [ROB_IDX_W-1:0] q,
                                           input logic rs_en, input logic [ROB_IDX_W-1:0] rs_q,
                                           input logic [DATA_W-1:0] rs_v,
                                           input logic cd_en, input logic [ROB_IDX_W-1:0] cd_q,
                                           input logic [DATA_W-1:0] cd_v);
      if (rs_en && q == rs_q) return {1'b1, rs_v};
      if (cd_en && q == cd_q) return {1'b1, cd_v};
      return '0;
   endfunction

   assign w_head     = r_ent[r_front];
   assign w_addr     = w_head.vj + w_head.offset;
   assign w_rb       = rdy_in & roll_back;
   assign w_disp     = rdy_in & de_in_en & ~roll_back & (r_count != cnt_t'(DEPTH));
   assign w_mem_fin  = (r_state != StIdle) & mem.mem_done;
   assign w_ld_fin   = (r_state == StWaitLd) & mem.mem_done;
   // An uncommitted in-flight load loses its result if flushed now or earlier
   assign w_drop_now = r_drop | (w_rb & ~r_if_cmt);
   assign w_issue    = rdy_in & ~roll_back & w_head.valid & ~w_head.qj_en & ~w_head.qk_en &
                       (w_head.committed | (~w_head.rw & (w_addr[17:16] != IO_SEL))) &
                       ((r_state == StIdle) | w_mem_fin);
   // A commit that lands on the entry being popped is carried by r_if_cmt instead
   assign w_cmt_inc  = (|w_cmt_hit) & ~(w_issue & w_cmt_hit[r_front]);

   assign lsb_full        = (cnt_t'(DEPTH) - r_count) <= cnt_t'(FULL_MARGIN);
   assign lsb_count       = r_count;
   assign cdb_out_en      = r_cdb_en;
   assign cdb_rob_idx_out = r_cdb_tag;
   assign cdb_val_out     = r_cdb_val;
   assign mem.mem_req     = r_mem_req;
   assign mem.mem_rw      = r_mem_rw;
   assign mem.mem_d_type  = r_mem_type;
   assign mem.mem_aout    = r_mem_addr;
   assign mem.mem_dout    = r_mem_data;

   lsb_load_ext u_load_ext (
      .i_op  (r_if_op),
      .i_raw (mem.mem_din),
      .o_val (w_ext_val)
   );

   // Per-entry next state: wakeup, commit marking, flush, pop and dispatch write
   always_comb begin
      logic [DATA_W:0] w_fj, w_fk;
      for (int i = 0; i < DEPTH; i++) begin
         w_ent_n[i]   = r_ent[i];
         w_cmt_hit[i] = rdy_in & rob_committed_en & ~roll_back & r_ent[i].valid &
                        ~r_ent[i].committed & (r_ent[i].tag == rob_committed_idx);
         w_fj = fwd(r_ent[i].qj, rs_in_en, rs_rob_idx_in, rs_val_in, r_cdb_en, r_cdb_tag, r_cdb_val);
         w_fk = fwd(r_ent[i].qk, rs_in_en, rs_rob_idx_in, rs_val_in, r_cdb_en, r_cdb_tag, r_cdb_val);
         if (r_ent[i].valid && r_ent[i].qj_en && w_fj[DATA_W]) begin
            w_ent_n[i].qj_en = 1'b0;
            w_ent_n[i].vj    = w_fj[DATA_W-1:0];
         end
         if (r_ent[i].valid && r_ent[i].qk_en && w_fk[DATA_W]) begin
            w_ent_n[i].qk_en = 1'b0;
            w_ent_n[i].vk    = w_fk[DATA_W-1:0];
         end
         if (w_cmt_hit[i]) w_ent_n[i].committed = 1'b1;
         if (w_rb && !r_ent[i].committed) w_ent_n[i].valid = 1'b0;
         if (w_issue && ptr_t'(i) == r_front) begin
            w_ent_n[i].valid     = 1'b0;
            w_ent_n[i].committed = 1'b0;
         end
      end
      w_fj = fwd(de_Qj_in, rs_in_en, rs_rob_idx_in, rs_val_in, r_cdb_en, r_cdb_tag, r_cdb_val);
      w_fk = fwd(de_Qk_in, rs_in_en, rs_rob_idx_in, rs_val_in, r_cdb_en, r_cdb_tag, r_cdb_val);
      if (w_disp) begin
         w_ent_n[r_rear].valid     = 1'b1;
         w_ent_n[r_rear].rw        = de_rw_in;
         w_ent_n[r_rear].committed = 1'b0;
         w_ent_n[r_rear].op        = de_op_in;
         w_ent_n[r_rear].offset    = de_offset_in;
         w_ent_n[r_rear].tag       = de_rob_idx_in;
         w_ent_n[r_rear].qj        = de_Qj_in;
         w_ent_n[r_rear].qk        = de_Qk_in;
         w_ent_n[r_rear].qj_en     = de_Qj_in_en & ~w_fj[DATA_W];
         w_ent_n[r_rear].qk_en     = de_Qk_in_en & ~w_fk[DATA_W];
         w_ent_n[r_rear].vj        = (de_Qj_in_en && w_fj[DATA_W]) ? w_fj[DATA_W-1:0] : de_Vj_in;
         w_ent_n[r_rear].vk        = (de_Qk_in_en && w_fk[DATA_W]) ? w_fk[DATA_W-1:0] : de_Vk_in;
      end
   end

   // Pointer and counter next state; a flush keeps only the committed prefix
   always_comb begin
      w_front_n = r_front + ptr_t'(w_issue);
      if (w_rb) begin
         w_rear_n   = r_front + r_ccount[PTR_W-1:0];
         w_count_n  = r_ccount;
         w_ccount_n = r_ccount;
      end else begin
         w_rear_n   = r_rear + ptr_t'(w_disp);
         w_count_n  = r_count + cnt_t'(w_disp) - cnt_t'(w_issue);
         w_ccount_n = r_ccount + cnt_t'(w_cmt_inc) - cnt_t'(w_issue & w_head.committed);
      end
   end

   // Memory FSM next state; an issue in the completion cycle goes straight back to waiting
   always_comb begin
      w_state_n = r_state;
      if (w_mem_fin) w_state_n = StIdle;
      if (w_issue)   w_state_n = w_head.rw ? StWaitSt : StWaitLd;
   end

   // State, queue and output registers; everything holds while rdy_in is low
   always_ff @(posedge clk) begin
      if (!rst_in) begin
         r_state    <= StIdle;
         r_front    <= '0;
         r_rear     <= '0;
         r_count    <= '0;
         r_ccount   <= '0;
         r_drop     <= 1'b0;
         r_if_cmt   <= 1'b0;
         r_if_op    <= '0;
         r_if_tag   <= '0;
         r_mem_req  <= 1'b0;
         r_mem_rw   <= 1'b0;
         r_mem_type <= '0;
         r_mem_addr <= '0;
         r_mem_data <= '0;
         r_cdb_en   <= 1'b0;
         r_cdb_tag  <= '0;
         r_cdb_val  <= '0;
         for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      end else if (rdy_in) begin
         r_state  <= w_state_n;
         r_front  <= w_front_n;
         r_rear   <= w_rear_n;
         r_count  <= w_count_n;
         r_ccount <= w_ccount_n;
         for (int i = 0; i < DEPTH; i++) r_ent[i] <= w_ent_n[i];
         if (w_issue) begin
            r_mem_req  <= 1'b1;
            r_mem_rw   <= w_head.rw;
            r_mem_type <= op_to_dtype(w_head.op);
            r_mem_addr <= w_addr;
            r_mem_data <= w_head.vk;
            r_if_op    <= w_head.op;
            r_if_tag   <= w_head.tag;
            r_if_cmt   <= w_head.committed | w_cmt_hit[r_front];
         end else if (w_mem_fin) begin
            r_mem_req <= 1'b0;
         end
         if (w_mem_fin) r_drop <= 1'b0;
         else if (w_rb && r_state == StWaitLd && !r_if_cmt) r_drop <= 1'b1;
         r_cdb_en <= w_ld_fin & ~w_drop_now;
         if (w_ld_fin) begin
            r_cdb_tag <= r_if_tag;
            r_cdb_val <= w_ext_val;
         end
      end
   end

endmodule

// File: doc/lsb_gen2.md
LSB_GEN2 -- requirements
Module: lsb_gen2

Interface
REQ-001 Parameter DEPTH, default 16: queue entries; power of two, at least 4.
REQ-002 Parameter ROB_IDX_W, default 4: ROB tag width.
REQ-003 Parameter FULL_MARGIN, default 3: free-slot threshold at and below which lsb_full asserts.
REQ-004 Parameter IO_SEL, default 2'b11: an address whose bits [17:16] equal IO_SEL is an IO address.
REQ-005 Ports:
- clk  in  1  system clock.
- rst_in  in  1  reset, synchronous, active-low.
- rdy_in  in  1  global stall; when low, all state holds.
- roll_back  in  1  misprediction flush.
- de_in_en, de_rw_in (1 = store)  in  1  dispatch valid and type.
- de_op_in  in  3  B/H/W/BU/HU.
- de_Vj_in, de_Vk_in, de_offset_in  in  32  base, store data, immediate.
- de_Qj_in_en, de_Qk_in_en  in  1  operand pending.
- de_Qj_in, de_Qk_in, de_rob_idx_in  in  ROB_IDX_W  operand tags and own tag.
- rs_in_en  in  1; rs_rob_idx_in  in  ROB_IDX_W; rs_val_in  in  32: RS broadcast.
- rob_committed_en  in  1; rob_committed_idx  in  ROB_IDX_W: in-order commit.
- mem_req  out  1  request valid, held until mem_done.
- mem_rw  out  1  1 = write.
- mem_d_type  out  2  01 byte, 10 half, 11 word.
- mem_aout, mem_dout  out  32  address and store data.
- mem_done  in  1  one-cycle completion pulse.
- mem_din  in  32  load data, valid with mem_done.
- lsb_full  out  1  free slots <= FULL_MARGIN.
- lsb_count  out  log2(DEPTH)+1  occupancy.
- cdb_out_en  out  1; cdb_rob_idx_out  out  ROB_IDX_W; cdb_val_out  out  32: load result broadcast.

Function
REQ-006 FIFO: front/rear pointers wrap modulo DEPTH; lsb_count = rear - front, held as its own count register so that DEPTH entries is distinct from empty.
REQ-007 Dispatch writes entry[rear] and increments rear; any tag matching a same-cycle RS or CDB broadcast is captured as ready with the broadcast value.
REQ-008 Every cycle, pending operands of all valid entries whose tag matches rs_rob_idx_in (rs_in_en) or cdb_rob_idx_out (cdb_out_en) capture the value and clear the pending flag.
REQ-009 A committed-count register ccount counts committed entries from front; on rob_committed_en, the entry whose tag matches is marked committed and ccount increments.
REQ-010 Only entry[front] can issue. Issue condition: state IDLE, both operands ready, and either committed, or (load and address not IO).
REQ-011 Address = Vj + offset, modulo 2^32.
REQ-012 States are IDLE, WAIT_LD and WAIT_ST.
- IDLE -> WAIT_LD or WAIT_ST on issue. The cycle after issue, mem_req=1 with address/type/data registered; the entry pops and ccount decrements if it was committed.
- WAIT_* -> IDLE on mem_done.
- A new issue is allowed in the mem_done cycle (back-to-back).
REQ-013 A load result is broadcast the cycle after mem_done, with cdb_out_en high for one cycle. B/H results are sign-extended; BU/HU results are zero-extended; W results pass through.
REQ-014 Stores produce no CDB broadcast.
REQ-015 roll_back:
- rear <= front + ccount, which discards all uncommitted entries; committed stores survive.
- An in-flight uncommitted load sets a drop flag. Its mem_done returns to IDLE without a broadcast.
- An in-flight store completes normally.
REQ-016 roll_back has priority over same-cycle dispatch and commit, which are ignored.
REQ-017 Simultaneous dispatch and pop leave lsb_count unchanged.
REQ-018 de_in_en while lsb_count == DEPTH is ignored.
REQ-019 Simultaneous commit and pop: ccount is unchanged.

Reset
REQ-020 While rst_in is low at a clk edge, the block sets:
- front, rear, lsb_count and ccount to 0;
- state to IDLE;
- all valid, committed and drop flags to 0;
- mem_req, mem_rw, mem_d_type, mem_aout, mem_dout, cdb_out_en, cdb_rob_idx_out and cdb_val_out to 0.
REQ-021 A reset during WAIT_* abandons the transaction; a later stray mem_done is ignored.

Structure
REQ-022 The shared param package holds the opcode encodings (LSB_B/H/W/BU/HU), the data and address widths, and the mem_d_type codes.
REQ-023 Extension logic is one sub-module, lsb_load_ext (op, raw -> value); the rest is flat.

Verification
REQ-024 Dispatch LW, base 0x100 ready, offset 4 -> mem_req, aout 0x104, type 11. After mem_done with din 0xDEADBEEF -> next cycle cdb_val_out 0xDEADBEEF with the load's tag.
REQ-025 LB with din 0x00000080 -> cdb_val_out 0xFFFFFF80; LBU with the same din -> 0x00000080.
REQ-026 Store with operands ready and not committed -> no mem_req. After rob_committed_en for its tag -> mem_req the next cycle, with rw=1.
REQ-027 LW to address 0x30000 -> no issue until committed.
REQ-028 Queue 1 committed SW then 3 uncommitted loads; roll_back -> lsb_count 1 and the store completes. Repeat with a load in flight -> mem_done yields no cdb_out_en.
REQ-029 DEPTH=4, FULL_MARGIN=1. Fill to 3 -> lsb_full=1. Wrap rear past 3 -> entries keep order. Dispatch plus pop in the same cycle -> count stable.
